// File: rtl/fib_index.sv
// Fibonacci index finder: walks F(0), F(1), ... one term per clock until the
// term reaches or passes the query, then reports a match flag and the index.
module fib_index #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned IDX_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_value,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             is_fib,
  output logic [IDX_W-1:0] fib_idx,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] target;
  logic [WIDTH+1:0] a;
  logic [WIDTH+1:0] b;
  logic [IDX_W-1:0] idx;
  logic [WIDTH+1:0] target_ext;

  // Two guard bits keep a+b exact up to the first term beyond 2^WIDTH-1.
  assign target_ext = {2'b00, target};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      target    <= '0;
      a         <= '0;
      b         <= '0;
      idx       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      is_fib    <= 1'b0;
      fib_idx   <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            target   <= in_value;
            a        <= '0;
            b        <= (WIDTH+2)'(1);
            idx      <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= SEARCH;
          end
        end
        SEARCH: begin
          if (a == target_ext) begin
            is_fib    <= 1'b1;
            fib_idx   <= idx;
            out_valid <= 1'b1;
            state     <= DONE;
          end else if (a > target_ext) begin
            is_fib    <= 1'b0;
            fib_idx   <= idx;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            a   <= b;
            b   <= a + b;
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fib_index.sv
// Bench for fib_index: directed queries with literal expectations plus
// randomized traffic checked every cycle against a transaction-level model.
module tb_fib_index;
  localparam int unsigned WIDTH = 32;
  localparam int unsigned IDX_W = 6;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] in_value = '0;
  logic             out_ready = 1'b1;
  logic             in_ready, out_valid, is_fib, busy;
  logic [IDX_W-1:0] fib_idx;

  int vectors = 0;
  int miscompares = 0;
  bit rand_rdy = 1'b0;

  fib_index #(.WIDTH(WIDTH), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_value(in_value),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .is_fib(is_fib), .fib_idx(fib_idx), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: walk the sequence in 64-bit arithmetic until it reaches v.
  function automatic void model(input logic [WIDTH-1:0] v, output bit f, output int n);
    longint unsigned x = 0, y = 1, t;
    n = 0;
    while (x < 64'(v)) begin
      t = x + y; x = y; y = t; n++;
    end
    f = (x == 64'(v));
  endfunction

  function automatic logic [WIDTH-1:0] fib_of(input int k);
    longint unsigned x = 0, y = 1, t;
    for (int i = 0; i < k; i++) begin
      t = x + y; x = y; y = t;
    end
    return x[WIDTH-1:0];
  endfunction

  // Transaction model: one job at a time, result due n+1 clocks after accept.
  bit               have_job = 1'b0;
  logic [WIDTH-1:0] job_val = '0;
  int               due = 0;
  int               cyc = 0;
  bit               ef;
  int               en;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      have_job = 1'b0;
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_is_fib", is_fib, 0);
      check("rst_fib_idx", fib_idx, 0);
    end else begin
      check("in_ready", in_ready, !have_job);
      check("busy", busy, have_job);
      check("out_valid", out_valid, have_job && cyc >= due);
      if (have_job && cyc >= due) begin
        model(job_val, ef, en);
        check("is_fib", is_fib, ef);
        check("fib_idx", fib_idx, en);
        if (out_ready) have_job = 1'b0;
      end else if (!have_job && in_valid) begin
        have_job = 1'b1;
        job_val  = in_value;
        model(in_value, ef, en);
        due = cyc + en + 2;
      end
    end
  end

  always @(posedge clk) begin
    if (rand_rdy) begin
      #1 out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic send(input logic [WIDTH-1:0] v, input logic [WIDTH-1:0] v_after);
    bit ok = 1'b0;
    in_valid = 1'b1;
    in_value = v;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_value = v_after;
    if (!ok) check("accept_timeout", 0, 1);
  endtask

  task automatic wait_result(input string tag, input bit xf, input int xn);
    int lat = 0;
    check({tag, "_ready_drop"}, in_ready, 0);
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_latency"}, lat, xn + 1);
    check({tag, "_is_fib"}, is_fib, xf);
    check({tag, "_fib_idx"}, fib_idx, xn);
  endtask

  task automatic take(input string tag);
    @(posedge clk);
    #1;
    check({tag, "_ready_back"}, in_ready, 1);
    check({tag, "_valid_drop"}, out_valid, 0);
  endtask

  task automatic query(input string tag, input logic [WIDTH-1:0] v, input bit xf, input int xn);
    send(v, v);
    wait_result(tag, xf, xn);
    take(tag);
  endtask

  initial begin
    bit mf;
    int mn;
    logic [WIDTH-1:0] v;

    // Pin the model to hand-derived values.
    model(32'd13, mf, mn);         check("model_13", {mf, 8'(mn)}, {1'b1, 8'd7});
    model(32'd1, mf, mn);          check("model_1", {mf, 8'(mn)}, {1'b1, 8'd1});
    model(32'd4, mf, mn);          check("model_4", {mf, 8'(mn)}, {1'b0, 8'd5});
    model(32'hFFFF_FFFF, mf, mn);  check("model_max", {mf, 8'(mn)}, {1'b0, 8'd48});

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    query("q13", 32'd13, 1'b1, 7);
    query("q0", 32'd0, 1'b1, 0);
    query("q1", 32'd1, 1'b1, 1);
    query("q2", 32'd2, 1'b1, 3);
    query("q4", 32'd4, 1'b0, 5);
    query("q47", 32'd2971215073, 1'b1, 47);
    query("qmax", 32'hFFFF_FFFF, 1'b0, 48);

    // Backpressure with a second request waiting behind the held result.
    out_ready = 1'b0;
    send(32'd21, 32'd21);
    wait_result("bp", 1'b1, 8);
    in_valid = 1'b1;
    in_value = 32'd100;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("bp_hold_valid", out_valid, 1);
      check("bp_hold_is_fib", is_fib, 1);
      check("bp_hold_idx", fib_idx, 8);
      check("bp_hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_ready_back", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("bp_second_accepted", busy, 1);
    wait_result("q100", 1'b0, 12);
    take("q100");

    // Query value changes after acceptance.
    send(32'd8, 32'd9);
    wait_result("q8", 1'b1, 6);
    take("q8");

    // Reset in the middle of a long search.
    send(32'd832040, 32'd832040);
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_fib_idx", fib_idx, 0);
    check("abort_in_ready", in_ready, 1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    query("q55", 32'd55, 1'b1, 10);

    // Randomized traffic; results checked by the per-cycle model.
    rand_rdy = 1'b1;
    for (int q = 0; q < 40; q++) begin
      case ($urandom_range(0, 3))
        0: v = fib_of(int'($urandom_range(0, 47)));
        1: begin
          v = fib_of(int'($urandom_range(2, 47)));
          v = $urandom_range(0, 1) ? v + 1'b1 : v - 1'b1;
        end
        2: v = $urandom;
        default: v = $urandom_range(0, 300);
      endcase
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      send(v, $urandom);
    end
    for (int i = 0; i < 400 && busy; i++) begin
      @(posedge clk);
      #1;
    end
    check("final_idle", busy, 0);
    rand_rdy = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
